// File: rtl/rgb_pwm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_pwm_sequencer: period counter plus boundary-aligned R/G/B compare      |
// | sequencing (direct load or linear fade).  Rev 1.0                          |
// +----------------------------------------------------------------------------+
module rgb_pwm_sequencer #(
  parameter int CTR_LEN = 8,
  parameter int STEP    = 1,
  parameter bit FADE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTR_LEN-1:0] in_r,
  input  logic [CTR_LEN-1:0] in_g,
  input  logic [CTR_LEN-1:0] in_b,
  output logic [CTR_LEN-1:0] cmp_r,
  output logic [CTR_LEN-1:0] cmp_g,
  output logic [CTR_LEN-1:0] cmp_b,
  output logic               period_tick,
  output logic               busy
);

  localparam logic [CTR_LEN-1:0] C_CTR_MAX = '1;
  localparam logic [CTR_LEN:0]   C_STEP    = (CTR_LEN+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FADE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CTR_LEN-1:0]        ctr_q, ctr_d;
  logic [2:0][CTR_LEN-1:0]   cmp_q, cmp_d;
  logic [2:0][CTR_LEN-1:0]   tgt_q, tgt_d;
  logic [2:0][CTR_LEN-1:0]   step_v;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      period_tick_q, period_tick_d;
  logic                      boundary;

  // One fade step; the extra bit keeps the distance compare free of wrap.
  function automatic logic [CTR_LEN-1:0] fade_step(input logic [CTR_LEN-1:0] cur,
                                                   input logic [CTR_LEN-1:0] tgt);
    logic [CTR_LEN:0]   c;
    logic [CTR_LEN:0]   t;
    logic [CTR_LEN-1:0] nxt;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    nxt = tgt;
    if (c < t) begin
      if ((t - c) > C_STEP) nxt = CTR_LEN'(c + C_STEP);
    end else if (c > t) begin
      if ((c - t) > C_STEP) nxt = CTR_LEN'(c - C_STEP);
    end
    return nxt;
  endfunction

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q + CTR_LEN'(1);
    cmp_d    = cmp_q;
    tgt_d    = tgt_q;
    boundary = (ctr_q == C_CTR_MAX);
    for (int i = 0; i < 3; i++) begin
      step_v[i] = fade_step(cmp_q[i], tgt_q[i]);
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          tgt_d   = {in_b, in_g, in_r};
          state_d = PEND;
        end
      end
      PEND, FADE: begin
        if (boundary) begin
          cmp_d   = FADE_EN ? step_v : tgt_q;
          state_d = (cmp_d == tgt_q) ? IDLE : FADE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d    = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    period_tick_d = (ctr_d == C_CTR_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      ctr_q         <= '0;
      cmp_q         <= '0;
      tgt_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      period_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      cmp_q         <= cmp_d;
      tgt_q         <= tgt_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      period_tick_q <= period_tick_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign period_tick = period_tick_q;
  assign cmp_r       = cmp_q[0];
  assign cmp_g       = cmp_q[1];
  assign cmp_b       = cmp_q[2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_sequencer.sv
`default_nettype none
// Bench for rgb_pwm_sequencer: a direct-load and a fading instance (CTR_LEN=4)
// checked against a period-level reference model plus hand-written sequences.
module tb_rgb_pwm_sequencer;

  localparam int CL     = 4;
  localparam int PER    = 16;
  localparam int STEP_F = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_r = '0, in_g = '0, in_b = '0;
  logic       v_d = 1'b0, v_f = 1'b0;
  logic       rdy_d, rdy_f, tick_d, tick_f, busy_d, busy_f;
  logic [3:0] cr_d, cg_d, cb_d, cr_f, cg_f, cb_f;

  always #5 clk = ~clk;

  rgb_pwm_sequencer #(.CTR_LEN(CL), .STEP(1), .FADE_EN(1'b0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(v_d), .in_ready(rdy_d),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .cmp_r(cr_d), .cmp_g(cg_d), .cmp_b(cb_d),
    .period_tick(tick_d), .busy(busy_d)
  );

  rgb_pwm_sequencer #(.CTR_LEN(CL), .STEP(STEP_F), .FADE_EN(1'b1)) dut_f (
    .clk(clk), .rst(rst), .in_valid(v_f), .in_ready(rdy_f),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .cmp_r(cr_f), .cmp_g(cg_f), .cmp_b(cb_f),
    .period_tick(tick_f), .busy(busy_f)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Reference model: index 0 = direct load, 1 = fade. "active" means a target
  // is held that has not yet been reached; it is worked on only at boundaries.
  int m_ctr = 0;
  bit m_tick = 0;
  int m_cmp [2][3];
  int m_tgt [2][3];
  bit m_act [2];
  bit m_rdy [2];
  bit m_acc [2];
  int md;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_ctr  = 0;
      m_tick = 0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_rdy[k] = 0; m_acc[k] = 0;
        for (int c = 0; c < 3; c++) begin
          m_cmp[k][c] = 0; m_tgt[k][c] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = ((k == 0) ? v_d : v_f) && m_rdy[k];
        if (m_act[k] && m_ctr == PER-1) begin
          m_act[k] = 0;
          for (int c = 0; c < 3; c++) begin
            md = m_tgt[k][c] - m_cmp[k][c];
            if (k == 0)      m_cmp[k][c] = m_tgt[k][c];
            else if (md > 0) m_cmp[k][c] += (md < STEP_F) ? md : STEP_F;
            else if (md < 0) m_cmp[k][c] -= (-md < STEP_F) ? -md : STEP_F;
            if (m_cmp[k][c] != m_tgt[k][c]) m_act[k] = 1;
          end
        end
        if (m_acc[k]) begin
          m_tgt[k][0] = int'(in_r);
          m_tgt[k][1] = int'(in_g);
          m_tgt[k][2] = int'(in_b);
          m_act[k]    = 1;
        end
        m_rdy[k] = !m_act[k];
      end
      m_ctr  = (m_ctr + 1) % PER;
      m_tick = (m_ctr == PER-1);
    end
  end

  function automatic logic [31:0] mpack(input int k);
    return {17'd0, 4'(m_cmp[k][0]), 4'(m_cmp[k][1]), 4'(m_cmp[k][2]),
            m_rdy[k], m_tick, m_act[k]};
  endfunction

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_direct", {17'd0, cr_d, cg_d, cb_d, rdy_d, tick_d, busy_d}, mpack(0));
      check("model_fade",   {17'd0, cr_f, cg_f, cb_f, rdy_f, tick_f, busy_f}, mpack(1));
    end
  end

  int acc_f = 0;
  initial forever begin
    @(posedge clk);
    if (v_f && rdy_f) acc_f++;
  end

  task automatic wait_ctr(input int c);
    int n = 0;
    while (m_ctr != c && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_ctr != c) timeout("wait_ctr");
  endtask

  task automatic wait_f_idle(output int nb);
    int n = 0;
    nb = 0;
    while (busy_f !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
      if (m_ctr == 0) nb++;
    end
    if (busy_f !== 1'b0) timeout("wait_fade_idle");
  endtask

  typedef struct {
    logic [3:0]  r, g, b;
    int          nb;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] traj [4];
  int          n, nb, acc_base;

  initial begin
    tbl[0] = '{4'd0,  4'd15, 4'd5,  3, 12'h0F5};
    tbl[1] = '{4'd10, 4'd2,  4'd5,  4, 12'hA25};
    tbl[2] = '{4'd10, 4'd2,  4'd5,  1, 12'hA25};
    tbl[3] = '{4'd15, 4'd15, 4'd15, 4, 12'hFFF};
    tbl[4] = '{4'd0,  4'd0,  4'd0,  4, 12'h000};
    tbl[5] = '{4'd7,  4'd8,  4'd9,  3, 12'h789};
    tbl[6] = '{4'd8,  4'd8,  4'd8,  1, 12'h888};
    tbl[7] = '{4'd0,  4'd15, 4'd5,  2, 12'h0F5};
    traj[0] = 12'h4B5; traj[1] = 12'h875; traj[2] = 12'hA35; traj[3] = 12'hA25;

    // Reset held with in_valid high
    rst = 1'b0; v_d = 1'b1; v_f = 1'b1;
    in_r = 4'd5; in_g = 4'd6; in_b = 4'd7;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cmp_d", {cr_d, cg_d, cb_d}, 12'h000);
    check("reset_cmp_f", {cr_f, cg_f, cb_f}, 12'h000);
    check("reset_ready", {rdy_d, rdy_f}, 2'b00);
    check("reset_busy",  {busy_d, busy_f}, 2'b00);
    check("reset_tick",  {tick_d, tick_f}, 2'b00);
    rst = 1'b1; v_d = 1'b0; v_f = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("ready_after_reset", {rdy_d, rdy_f}, 2'b11);
    end while (tick_d !== 1'b1 && n < 40);
    check("first_tick_delay", n, 15);

    // Direct load accepted at ctr=4
    wait_ctr(4);
    in_r = 4'd9; in_g = 4'd3; in_b = 4'd15; v_d = 1'b1; v_f = 1'b1;
    @(negedge clk);
    v_d = 1'b0; v_f = 1'b0;
    check("pend_busy_ready", {busy_d, rdy_d}, 2'b10);
    while (m_ctr != 0) begin
      check("direct_hold", {cr_d, cg_d, cb_d}, 12'h000);
      @(negedge clk);
    end
    check("direct_load", {cr_d, cg_d, cb_d}, 12'h93F);
    check("direct_ready_busy", {rdy_d, busy_d}, 2'b10);
    check("fade_first_step", {cr_f, cg_f, cb_f}, 12'h434);
    wait_f_idle(nb);
    check("fade_rest_periods", nb, 3);
    check("fade_final", {cr_f, cg_f, cb_f}, 12'h93F);

    // Table of targets for both instances
    for (int i = 0; i < 8; i++) begin
      wait_ctr(2);
      in_r = tbl[i].r; in_g = tbl[i].g; in_b = tbl[i].b;
      v_d = 1'b1; v_f = 1'b1;
      @(negedge clk);
      v_d = 1'b0; v_f = 1'b0;
      wait_f_idle(nb);
      check($sformatf("tbl%0d_periods", i), nb, tbl[i].nb);
      check($sformatf("tbl%0d_fade_cmp", i), {cr_f, cg_f, cb_f}, tbl[i].exp);
      check($sformatf("tbl%0d_direct_cmp", i), {cr_d, cg_d, cb_d}, tbl[i].exp);
      check($sformatf("tbl%0d_idle", i), {rdy_d, busy_d, rdy_f, busy_f}, 4'b1010);
    end

    // Fade trajectory (0,15,5) -> (10,2,5) with STEP=4
    wait_ctr(2);
    in_r = 4'd10; in_g = 4'd2; in_b = 4'd5; v_f = 1'b1;
    @(negedge clk);
    v_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ctr(0);
      check($sformatf("traj%0d_cmp", k), {cr_f, cg_f, cb_f}, traj[k]);
      check($sformatf("traj%0d_busy", k), busy_f, (k < 3) ? 1 : 0);
      @(negedge clk);
    end

    // Accept on the boundary edge waits a full period
    wait_ctr(15);
    in_r = 4'd1; in_g = 4'd2; in_b = 4'd3; v_d = 1'b1;
    @(negedge clk);
    v_d = 1'b0;
    check("bnd_no_change", {cr_d, cg_d, cb_d}, 12'h0F5);
    check("bnd_busy", busy_d, 1);
    wait_ctr(15);
    check("bnd_still_old", {cr_d, cg_d, cb_d}, 12'h0F5);
    @(negedge clk);
    check("bnd_applied", {cr_d, cg_d, cb_d}, 12'h123);
    check("bnd_idle", busy_d, 0);

    // Backpressure during a fade
    acc_base = acc_f;
    wait_ctr(2);
    in_r = 4'd15; in_g = 4'd15; in_b = 4'd15; v_f = 1'b1;
    @(negedge clk);
    in_r = 4'd3; in_g = 4'd3; in_b = 4'd3;
    n = 0;
    while (rdy_f !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy_f !== 1'b1) timeout("bp_ready");
    check("bp_first_target", {cr_f, cg_f, cb_f}, 12'hFFF);
    @(negedge clk);
    v_f = 1'b0;
    check("bp_second_pend", {rdy_f, busy_f}, 2'b01);
    wait_f_idle(nb);
    check("bp_periods", nb, 3);
    check("bp_second_target", {cr_f, cg_f, cb_f}, 12'h333);
    check("bp_accept_count", acc_f - acc_base, 2);

    // Reset in the middle of a fade
    wait_ctr(2);
    in_r = 4'd15; in_g = 4'd0; in_b = 4'd15; v_f = 1'b1;
    @(negedge clk);
    v_f = 1'b0;
    wait_ctr(0);
    check("midfade_step", {cr_f, cg_f, cb_f, busy_f}, 13'h0E0F);
    @(negedge clk);
    wait_ctr(7);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_cmp", {cr_f, cg_f, cb_f}, 12'h000);
    check("midreset_flags", {rdy_f, busy_f, tick_f}, 3'b000);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_discarded", {cr_f, cg_f, cb_f, busy_f}, 13'h0000);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (v_d && m_acc[0]) v_d = 1'b0;
      if (v_f && m_acc[1]) v_f = 1'b0;
      if (!v_d && !v_f) begin
        in_r = 4'($urandom); in_g = 4'($urandom); in_b = 4'($urandom);
      end
      if (!v_d && $urandom_range(0, 5) == 0) v_d = 1'b1;
      if (!v_f && $urandom_range(0, 5) == 0) v_f = 1'b1;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
    end

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_pwm_sequencer.md
Name: rgb_pwm_sequencer

Overview:
- Sequences the compare inputs of the three colour PWM channels (R, G, B) in the analog-to-RGB path.
- Owns a free-running period counter, shared with the PWM slaves through `period_tick`.
- Accepts new colour targets from the upstream sampler over a valid/ready handshake.
- Applies each target only at a PWM period boundary, either as a direct load or as a linear fade, so no period ever sees a torn or glitched duty cycle.

Parameters:
- `CTR_LEN`, 8: width of the period counter and of every compare value; period = 2^CTR_LEN cycles.
- `STEP`, 1: maximum change per channel per period while fading; legal range 1..2^CTR_LEN-1.
- `FADE_EN`, 1: 1 = ramp towards the target; 0 = load the target at the next boundary.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-low (`rst`=0 resets on the next rising edge of `clk`).
- `in_valid`  in  1  upstream target valid; must be held until accepted.
- `in_ready`  out  1  sequencer can accept a target.
- `in_r`, `in_g`, `in_b`  in  `CTR_LEN` each  target compare values; sampled only on accept.
- `cmp_r`, `cmp_g`, `cmp_b`  out  `CTR_LEN` each  compare values driven to the PWM channels.
- `period_tick`  out  1  high for one cycle, the last cycle of each period.
- `busy`  out  1  a target is pending or a fade is in progress.

Behaviour:
- **Reset (`rst`=0):**
  - `ctr`=0; `cmp_r`/`cmp_g`/`cmp_b`=0; state IDLE.
  - `in_ready`=0, `period_tick`=0, `busy`=0.
  - `in_ready` rises on the first edge after `rst` returns to 1.
  - Reset mid-fade or while PEND discards the target and restores all of the above.
- **Period counter `ctr`:**
  - Free-running, increments by 1 every cycle; wraps from 2^CTR_LEN-1 to 0.
  - Boundary cycle = cycle where `ctr`==2^CTR_LEN-1.
  - `period_tick` is a registered output, high exactly in boundary cycles.
- **Compare update timing:**
  - `cmp_*` registers change only on the edge that ends a boundary cycle.
  - New values are visible from the cycle where `ctr`==0.
  - `cmp_*` never changes at any other edge.
- **Handshake:**
  - Accept = `in_valid` && `in_ready` at a rising edge; `in_r`/`in_g`/`in_b` are captured into the target register `tgt` on that edge.
  - `in_ready`=1 only in IDLE. It is registered and drops on the accept edge.
  - `in_valid` while not ready: no effect; the source holds its data.
- **States:**
  - IDLE: `in_ready`=1, `busy`=0. On accept: capture `tgt`, go to PEND.
  - PEND: `in_ready`=0, `busy`=1. Waits for the next boundary cycle. An accept that lands on a boundary edge waits for the following boundary (one full period).
  - At the PEND boundary with `FADE_EN`=0: `cmp_*`=`tgt_*`, go to IDLE.
  - At the PEND boundary with `FADE_EN`=1: perform the first fade step. If all three channels then equal their targets, go to IDLE; otherwise go to FADE.
  - FADE: `busy`=1. At each boundary, each channel steps as defined below. When all three equal their targets after a step, go to IDLE.
- **Fade arithmetic (unsigned, per channel independently):**
  - `cmp` < `tgt`: `cmp` += min(`STEP`, `tgt`-`cmp`).
  - `cmp` > `tgt`: `cmp` -= min(`STEP`, `cmp`-`tgt`).
  - Equal: hold.
  - No overshoot and no wrap; intermediate values use `CTR_LEN`+1 bits.
  - Channels finish independently; a finished channel holds while the others continue.
- **Edge cases:**
  - Target equal to the current `cmp_*`: goes through PEND, no `cmp` change, IDLE after the first boundary.
  - `cmp`=2^CTR_LEN-1 yields duty (2^CTR_LEN-1)/2^CTR_LEN; `cmp`=0 yields 0% (slave output is high while `cmp` > counter).
- **Latency:**
  - `FADE_EN`=0: accept-to-`cmp` latency ranges from 1 cycle (accept on the edge into the boundary cycle) to 2^CTR_LEN cycles (accept on a boundary edge).
  - `FADE_EN`=1: the fade completes after ceil(max|Δ|/`STEP`) boundaries.

Test Plan:
All scenarios use `CTR_LEN`=4 (16-cycle period).
1. Reset: hold `rst`=0 for 3 cycles with `in_valid`=1 → `cmp_*`=0, `in_ready`=0, `busy`=0. After release, `in_ready`=1 next cycle and `period_tick` first high when `ctr`=15.
2. Direct load, `FADE_EN`=0: accept R/G/B=(9,3,15) while `ctr`=4 → `cmp_*` unchanged through `ctr`=15; `cmp_*`=(9,3,15) at `ctr`=0; `in_ready`=1 again the following cycle.
3. Fade, `FADE_EN`=1, `STEP`=4, start from (0,15,5), target (10,2,5):
   - `cmp_r` goes 4, 8, 10.
   - `cmp_g` goes 11, 7, 3, 2.
   - `cmp_b` stays 5.
   - `busy` falls after the 4th boundary; no overshoot.
4. Boundary accept: assert `in_valid` so that the accept lands on the edge ending `ctr`=15 → no change at `ctr`=0; the update appears one full period later at the next `ctr`=0.
5. Backpressure: hold `in_valid`=1 with new data during FADE → `in_ready` stays 0 and data is not captured until IDLE, then accepted exactly once.
6. Reset mid-fade: assert `rst`=0 during FADE at `ctr`=7 → next cycle `cmp_*`=0, `busy`=0, `ctr`=0; the old target is never applied.
